// File: rtl/lut_neuron_stream.sv
// Reloadable LUT neuron: a RAM truth table indexed by the concatenated quantised inputs,
// filled over a config stream and read through a one-deep valid/ready output register.
module lut_neuron_stream #(
  parameter  int FAN_IN   = 4,
  parameter  int IN_BITS  = 2,
  parameter  int OUT_BITS = 2,
  localparam int ADDR_W   = FAN_IN * IN_BITS,
  localparam int DEPTH    = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                busy_load
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cfg_done;
  logic                r_out_valid;
  logic [OUT_BITS-1:0] r_out_data;
  logic [OUT_BITS-1:0] r_table [DEPTH];

  logic                w_cfg_fire;
  logic                w_in_fire;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [OUT_BITS-1:0] w_lookup;

  assign cfg_ready  = (r_state == S_LOAD);
  assign busy_load  = (r_state == S_LOAD);
  // A reload request blocks the lookup offered in the same cycle.
  assign in_ready   = (r_state == S_RUN) && !cfg_start && (!r_out_valid || out_ready);
  assign w_cfg_fire = cfg_ready && cfg_valid;
  assign w_in_fire  = in_valid && in_ready;
  assign w_wr_addr  = cfg_start ? '0 : r_addr;
  assign w_lookup   = r_table[in_data];

  assign cfg_done  = r_cfg_done;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (w_cfg_fire) begin
      r_table[w_wr_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_addr      <= '0;
      r_cfg_done  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_cfg_fire) begin
            if (cfg_start) begin
              r_addr <= ADDR_W'(1);
            end else if (&r_addr) begin
              r_addr     <= '0;
              r_cfg_done <= 1'b1;
              r_state    <= S_RUN;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end else if (cfg_start) begin
            r_addr <= '0;
          end
        end
        S_RUN: begin
          if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_lookup;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (cfg_start) begin
            if (r_out_valid) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_LOAD;
              r_addr  <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (!r_out_valid || out_ready) begin
            r_state <= S_LOAD;
            r_addr  <= '0;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_neuron_stream.sv
// Randomised bench for lut_neuron_stream: a table array plus a queue of pending results
// serve as the reference for loads, lookups, backpressure, drain and reload.
module tb_lut_neuron_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_data;
  logic       cfg_done;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       busy_load;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_tab  [256];
  logic [1:0] tab_next [256];
  logic [1:0] sb [$];

  always #5 clk = ~clk;

  lut_neuron_stream dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy_load (busy_load)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_cfg_done",  32'(cfg_done),  32'd0);
    chk("rst_busy_load", 32'(busy_load), 32'd1);
    $display("reset check at t=%0t", $time);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cfg_valid = 1'b0; cfg_start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
  endtask

  // Feed n words from tab_next; optionally raise cfg_start with the first word.
  task automatic load(input int n, input bit start_first);
    int idx = 0;
    int guard = 0;
    bit first = 1'b1;
    while (idx < n && guard < 4000) begin
      @(posedge clk); #1;
      cfg_start = first && start_first;
      cfg_valid = (first && start_first) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cfg_data  = tab_next[idx];
      in_valid  = 1'b1;
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("ld_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("ld_in_ready",  32'(in_ready),  32'd0);
      chk("ld_busy",      32'(busy_load), 32'd1);
      chk("ld_out_valid", 32'(out_valid), 32'd0);
      chk("ld_cfg_done",  32'(cfg_done),  32'd0);
      if (cfg_valid) begin
        exp_tab[idx] = tab_next[idx];
        idx++;
      end
      first = 1'b0;
      guard++;
    end
    if (guard >= 4000) chk("ld_timeout", 32'(idx), 32'(n));
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    if (n == 256) begin
      chk("done_pulse", 32'(cfg_done),  32'd1);
      chk("done_busy",  32'(busy_load), 32'd0);
      chk("done_cfgr",  32'(cfg_ready), 32'd0);
      @(posedge clk); #1; #1;
      chk("done_clear", 32'(cfg_done),  32'd0);
    end else begin
      chk("partial_no_done", 32'(cfg_done),  32'd0);
      chk("partial_busy",    32'(busy_load), 32'd1);
    end
    $display("load n=%0d start_first=%0d t=%0t", n, start_first, $time);
  endtask

  // One cycle of the lookup interface; running=0 means a reload is pending (drain).
  task automatic cycle(input bit iv, input logic [7:0] id, input bit ordy, input bit cs,
                       input bit running);
    bit exp_ov;
    bit exp_ir;
    @(posedge clk); #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cfg_start = cs;
    cfg_valid = 1'($urandom_range(0, 1));
    cfg_data  = 2'($urandom_range(0, 3));
    #1;
    exp_ov = (sb.size() != 0);
    exp_ir = running && !cs && (!exp_ov || ordy);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) chk("out_data", 32'(out_data), 32'(sb[0]));
    chk("in_ready",  32'(in_ready),  32'(exp_ir));
    chk("run_cfgr",  32'(cfg_ready), 32'd0);
    chk("run_busy",  32'(busy_load), 32'd0);
    if (exp_ov && ordy) void'(sb.pop_front());
    if (iv && exp_ir) sb.push_back(exp_tab[id]);
    $display("cyc iv=%0d addr=%02h ordy=%0d cs=%0d ov=%0d od=%0d ir=%0d", iv, id, ordy, cs,
             out_valid, out_data, in_ready);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0), 1'b0, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    do_reset();

    for (int i = 0; i < 256; i++) tab_next[i] = 2'b00;
    tab_next[8'h00] = 2'b01;
    tab_next[8'h02] = 2'b10;
    tab_next[8'h42] = 2'b01;
    load(256, 1'b0);

    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h42, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    cycle(1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h42, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    random_run(200);

    // Reload requested with a result stuck at the output.
    cycle(1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) tab_next[i] = 2'b11;
    load(256, 1'b0);
    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    random_run(50);

    // Reload from an idle output, abandoned after 100 words and restarted.
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) tab_next[i] = 2'($urandom_range(0, 3));
    load(100, 1'b0);
    for (int i = 0; i < 256; i++) tab_next[i] = 2'b10;
    load(256, 1'b1);
    random_run(100);

    // Reset in the middle of a load.
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) tab_next[i] = 2'($urandom_range(0, 3));
    load(50, 1'b0);
    do_reset();
    for (int i = 0; i < 256; i++) tab_next[i] = 2'($urandom_range(0, 3));
    load(256, 1'b0);
    random_run(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
